// File: rtl/rc5_core_if.sv
// Host/key-schedule handshake bundle for rc5_core: block in, block out, subkey write port.
interface rc5_core_if #(
    parameter int W  = 16,
    parameter int AW = 6
);
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [7:0]     in_rounds;
    logic [2*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;
    logic           sk_we;
    logic [AW-1:0]  sk_addr;
    logic [W-1:0]   sk_data;
    logic           sk_ready;

    modport master (
        output in_valid, in_mode, in_rounds, in_data, out_ready, sk_we, sk_addr, sk_data,
        input  in_ready, out_valid, out_data, sk_ready
    );

    modport slave (
        input  in_valid, in_mode, in_rounds, in_data, out_ready, sk_we, sk_addr, sk_data,
        output in_ready, out_valid, out_data, sk_ready
    );
endinterface

// File: rtl/rc5_core.sv
// Iterative RC5-W/r engine: one round per clock, encrypt or decrypt, register-file subkey table.
module rc5_core #(
    parameter int W          = 16,
    parameter int MAX_ROUNDS = 16
) (
    input logic       clk,
    input logic       rst,
    rc5_core_if.slave bus
);
    localparam int LGW = $clog2(W);
    localparam int T   = 2 * (MAX_ROUNDS + 1);
    localparam int AW  = $clog2(T);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a, b;
    logic [W-1:0]  s [T];
    logic          mode;
    logic [7:0]    idx, r_eff, r_in;
    logic [AW-1:0] ka, kb;
    logic [W-1:0]  s_a, s_b;
    logic [W-1:0]  a_enc, b_enc, a_dec, b_dec;
    logic          accept, last;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} >> n;
        return t[W-1:0];
    endfunction

    assign r_in          = (bus.in_rounds > 8'(MAX_ROUNDS)) ? 8'(MAX_ROUNDS) : bus.in_rounds;
    assign bus.in_ready  = (state == IDLE) && rst;
    assign bus.sk_ready  = bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = mode ? (idx == 8'd1) : (idx == r_eff);

    assign ka  = AW'({idx, 1'b0});
    assign kb  = ka | AW'(1);
    assign s_a = s[ka];
    assign s_b = s[kb];

    always_comb begin
        a_enc = rotl(a ^ b, b[LGW-1:0]) + s_a;
        b_enc = rotl(b ^ a_enc, a_enc[LGW-1:0]) + s_b;
        b_dec = rotr(b - s_b, a[LGW-1:0]) ^ a;
        a_dec = rotr(a - s_a, b_dec[LGW-1:0]) ^ b_dec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (r_in == 8'd0) ? DONE : ROUND;
            ROUND:   if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // idx holds on the final round so the subkey read index never leaves the table
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a     <= '0;
            b     <= '0;
            idx   <= '0;
            mode  <= 1'b0;
            r_eff <= '0;
        end else if (accept) begin
            mode  <= bus.in_mode;
            r_eff <= r_in;
            if (bus.in_mode) begin
                a   <= bus.in_data[W-1:0];
                b   <= bus.in_data[2*W-1:W];
                idx <= r_in;
            end else begin
                a   <= bus.in_data[W-1:0] + s[0];
                b   <= bus.in_data[2*W-1:W] + s[1];
                idx <= 8'd1;
            end
        end else if (state == ROUND) begin
            a <= mode ? a_dec : a_enc;
            b <= mode ? b_dec : b_enc;
            if (!last) idx <= mode ? idx - 8'd1 : idx + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < T; i++) s[i] <= '0;
        end else if (bus.sk_we && bus.sk_ready && (int'(bus.sk_addr) < T)) begin
            s[bus.sk_addr] <= bus.sk_data;
        end
    end

    always_comb begin
        bus.out_data = '0;
        if (state == DONE)
            bus.out_data = mode ? {b - s[1], a - s[0]} : {b, a};
    end
endmodule

// File: tb/tb_rc5_core.sv
// Self-checking bench for rc5_core: W=16/MAX_ROUNDS=16 and W=32/MAX_ROUNDS=12 instances.
module tb_rc5_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel, iv, mode, ordy, we;
    logic [7:0]  rounds, addr;
    logic [63:0] din, sdata;
    logic        ir, ov;
    logic [63:0] od;
    int          total = 0;
    int          bad   = 0;
    longint unsigned k16 [34];
    longint unsigned k32 [26];

    always #5 clk = ~clk;

    rc5_core_if #(.W(16), .AW(6)) b16 ();
    rc5_core_if #(.W(32), .AW(5)) b32 ();

    rc5_core #(.W(16), .MAX_ROUNDS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    rc5_core #(.W(32), .MAX_ROUNDS(12)) dut32 (.clk(clk), .rst(rst), .bus(b32));

    assign b16.in_valid  = iv && !sel;
    assign b16.in_mode   = mode;
    assign b16.in_rounds = rounds;
    assign b16.in_data   = din[31:0];
    assign b16.out_ready = ordy && !sel;
    assign b16.sk_we     = we && !sel;
    assign b16.sk_addr   = addr[5:0];
    assign b16.sk_data   = sdata[15:0];
    assign b32.in_valid  = iv && sel;
    assign b32.in_mode   = mode;
    assign b32.in_rounds = rounds;
    assign b32.in_data   = din;
    assign b32.out_ready = ordy && sel;
    assign b32.sk_we     = we && sel;
    assign b32.sk_addr   = addr[4:0];
    assign b32.sk_data   = sdata[31:0];
    assign ir = sel ? b32.in_ready  : b16.in_ready;
    assign ov = sel ? b32.out_valid : b16.out_valid;
    assign od = sel ? b32.out_data  : {32'b0, b16.out_data};

    function automatic longint unsigned msk(int w);
        return (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    endfunction

    function automatic longint unsigned m_rotl(longint unsigned x, longint unsigned n, int w);
        longint unsigned k = n % w;
        return ((x << k) | (x >> (w - k))) & msk(w);
    endfunction

    function automatic longint unsigned m_rotr(longint unsigned x, longint unsigned n, int w);
        longint unsigned k = n % w;
        return ((x >> k) | (x << (w - k))) & msk(w);
    endfunction

    function automatic longint unsigned key(bit s, int i);
        return s ? k32[i] : k16[i];
    endfunction

    function automatic int eff(bit s, int r);
        int mr = s ? 12 : 16;
        return (r > mr) ? mr : r;
    endfunction

    function automatic longint unsigned m_enc(bit s, longint unsigned blk, int r);
        int w = s ? 32 : 16;
        longint unsigned m = msk(w);
        longint unsigned a = ((blk & m) + key(s, 0)) & m;
        longint unsigned b = (((blk >> w) & m) + key(s, 1)) & m;
        for (int i = 1; i <= eff(s, r); i++) begin
            a = (m_rotl(a ^ b, b, w) + key(s, 2*i)) & m;
            b = (m_rotl(b ^ a, a, w) + key(s, 2*i+1)) & m;
        end
        return (b << w) | a;
    endfunction

    function automatic longint unsigned m_dec(bit s, longint unsigned blk, int r);
        int w = s ? 32 : 16;
        longint unsigned m = msk(w);
        longint unsigned a = blk & m;
        longint unsigned b = (blk >> w) & m;
        for (int i = eff(s, r); i >= 1; i--) begin
            b = m_rotr((b - key(s, 2*i+1)) & m, a, w) ^ a;
            a = m_rotr((a - key(s, 2*i)) & m, b, w) ^ b;
        end
        a = (a - key(s, 0)) & m;
        b = (b - key(s, 1)) & m;
        return (b << w) | a;
    endfunction

    // Standard RC5-32 key expansion for a 16-byte all-zero key.
    task automatic kexp32();
        longint unsigned l [4];
        longint unsigned x = 0, y = 0;
        int i = 0, j = 0;
        for (int n = 0; n < 4; n++) l[n] = 0;
        k32[0] = 64'hB7E1_5163;
        for (int n = 1; n < 26; n++) k32[n] = (k32[n-1] + 64'h9E37_79B9) & 64'hFFFF_FFFF;
        for (int n = 0; n < 78; n++) begin
            x = m_rotl((k32[i] + x + y) & 64'hFFFF_FFFF, 3, 32);
            k32[i] = x;
            y = m_rotl((l[j] + x + y) & 64'hFFFF_FFFF, x + y, 32);
            l[j] = y;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit s, input int a, input longint unsigned v);
        @(negedge clk);
        sel = s; we = 1'b1; addr = 8'(a); sdata = v;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic run(input bit s, input bit m, input int r, input logic [63:0] d,
                       input int hold, output logic [63:0] dout, output int lat);
        int n = 0;
        @(negedge clk);
        sel = s; mode = m; rounds = 8'(r); din = d; iv = 1'b1;
        #1;
        while (!ir && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!ir) chk("accept_timeout", {63'b0, ir}, 64'd1);
        @(negedge clk);
        iv = 1'b0;
        lat = 1;
        while (!ov && lat < 300) begin
            chk("idle_out_zero", od, 64'd0);
            @(negedge clk); lat++;
        end
        if (!ov) chk("done_timeout", {63'b0, ov}, 64'd1);
        dout = od;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 1) begin
                we = 1'b1; addr = 8'd2; sdata = key(s, 2) ^ 64'h5A5A;
            end else begin
                we = 1'b0;
            end
            chk("hold_data", od, dout);
            chk("hold_ready", {63'b0, ir}, 64'd0);
            chk("hold_valid", {63'b0, ov}, 64'd1);
        end
        we = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("back_to_idle", {62'b0, ov, ir}, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dout, dd, ct;
        int lat, r;
        rst = 1'b0; sel = 1'b0; iv = 1'b0; mode = 1'b0; ordy = 1'b0; we = 1'b0;
        rounds = '0; addr = '0; din = '0; sdata = '0;
        for (int i = 0; i < 34; i++) k16[i] = 0;
        kexp32();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            chk("rst_in_ready", {63'b0, ir}, 64'd0);
            chk("rst_out_valid", {63'b0, ov}, 64'd0);
            chk("rst_out_data", od, 64'd0);
        end
        chk("rst_sk_ready", {63'b0, b16.sk_ready}, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); sel = 1'b0; #1;
        chk("idle_ready", {63'b0, ir}, 64'd1);

        wr(0, 0, 1); wr(0, 1, 2);
        k16[0] = 1; k16[1] = 2;
        run(0, 0, 0, 0, 0, dout, lat);
        chk("r0_enc", dout, 64'h0002_0001);
        chk("r0_enc_lat", 64'(lat), 64'd1);
        run(0, 1, 0, 0, 0, dout, lat);
        chk("r0_dec", dout, 64'hFFFE_FFFF);
        chk("r0_dec_lat", 64'(lat), 64'd1);

        for (int i = 0; i < 26; i++) wr(1, i, k32[i]);
        run(1, 0, 12, 0, 0, dout, lat);
        chk("kat32_enc", dout, 64'h6D8F4B15_EEDBA521);
        chk("kat32_model", dout, m_enc(1, 0, 12));
        chk("kat32_lat", 64'(lat), 64'd13);
        run(1, 1, 12, dout, 0, dout, lat);
        chk("kat32_dec", dout, 64'd0);
        chk("kat32_dec_lat", 64'(lat), 64'd13);

        for (int i = 0; i < 34; i++) begin
            k16[i] = $urandom & 32'hFFFF;
            wr(0, i, k16[i]);
        end
        for (int n = 0; n < 1000; n++) begin
            dd = {32'b0, $urandom};
            r  = $urandom_range(0, 16);
            run(0, 0, r, dd, 0, ct, lat);
            chk("rt_enc", ct, m_enc(0, dd, r));
            chk("rt_enc_lat", 64'(lat), 64'(r + 1));
            run(0, 1, r, ct, 0, dout, lat);
            chk("rt_dec", dout, dd);
            chk("rt_dec_lat", 64'(lat), 64'(r + 1));
            if (n % 20 == 0) begin
                dd = {32'b0, $urandom};
                run(0, 1, r, dd, 0, dout, lat);
                chk("rand_dec", dout, m_dec(0, dd, r));
            end
        end

        dd = {32'b0, $urandom};
        run(0, 0, 20, dd, 0, dout, lat);
        chk("clamp_data", dout, m_enc(0, dd, 16));
        chk("clamp_lat", 64'(lat), 64'd17);

        dd = {32'b0, $urandom};
        run(0, 0, 5, dd, 5, dout, lat);
        chk("bp_data", dout, m_enc(0, dd, 5));
        run(0, 0, 5, dd, 0, dout, lat);
        chk("bp_sk_dropped", dout, m_enc(0, dd, 5));

        @(negedge clk);
        sel = 1'b0; mode = 1'b0; rounds = 8'd8; din = {32'b0, $urandom}; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; #1;
        chk("mid_rst_valid", {63'b0, ov}, 64'd0);
        chk("mid_rst_ready", {63'b0, ir}, 64'd0);
        chk("mid_rst_data", od, 64'd0);
        for (int i = 0; i < 34; i++) k16[i] = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ready", {63'b0, ir}, 64'd1);
        run(0, 0, 0, 0, 0, dout, lat);
        chk("post_rst_zero", dout, 64'd0);
        dd = {32'b0, $urandom};
        run(0, 0, 4, dd, 0, dout, lat);
        chk("post_rst_table", dout, m_enc(0, dd, 4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
